// File: rtl/ryu_pixel_sched_if.sv
// Pixel-slot bus between the sprite index logic, the palette LUT and the VGA colour path.
// The slave side is the scheduler; the master side is the sprite/LUT/VGA environment.
interface ryu_pixel_sched_if;
    logic        frame_start;
    logic        pix_valid;
    logic [4:0]  p1_index;
    logic [4:0]  p2_index;
    logic        p1_attack;
    logic        p2_attack;
    logic        p1_hit;
    logic        p2_hit;
    logic [11:0] bg_rgb;
    logic [4:0]  pal_index;
    logic [11:0] pal_rgb;
    logic [11:0] vga_rgb;
    logic        vga_valid;

    modport slave (
        input  frame_start, pix_valid, p1_index, p2_index,
        input  p1_attack, p2_attack, p1_hit, p2_hit, bg_rgb, pal_rgb,
        output pal_index, vga_rgb, vga_valid
    );

    modport master (
        output frame_start, pix_valid, p1_index, p2_index,
        output p1_attack, p2_attack, p1_hit, p2_hit, bg_rgb, pal_rgb,
        input  pal_index, vga_rgb, vga_valid
    );
endinterface

// File: rtl/ryu_pixel_sched.sv
// Two-stage pixel scheduler sharing one palette LUT between P1, P2 and background, with hit flash.
// Optional macro RYU_P2_TINT_EN: red/blue swap of non-flashing P2 pixels for mirror matches.
module ryu_pixel_sched #(
    parameter int FLASH_FRAMES  = 4,
    parameter int FLASH_TOGGLES = 6,
    parameter int TRANSP_IDX    = 0
) (
    input logic              Clk,
    input logic              Reset,
    ryu_pixel_sched_if.slave bus
);
    localparam int FW = (FLASH_FRAMES  > 1) ? $clog2(FLASH_FRAMES)  : 1;
    localparam int PW = (FLASH_TOGGLES > 1) ? $clog2(FLASH_TOGGLES) : 1;
    localparam logic [FW-1:0] FR_LAST = FW'(FLASH_FRAMES - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(FLASH_TOGGLES - 1);
    localparam logic [4:0]    TRANSP  = 5'(TRANSP_IDX);

    typedef enum logic [1:0] {OWN_BG, OWN_P1, OWN_P2} owner_t;
    typedef enum logic [1:0] {FL_IDLE, FL_ON, FL_OFF} flash_state_t;

    logic        r_front_p2;
    logic [4:0]  r_pal_index;
    owner_t      r_owner;
    logic [11:0] r_bg_rgb;
    logic        r_s1_valid;
    logic [11:0] r_vga_rgb;
    logic        r_vga_valid;

    logic [4:0]  w_front_idx;
    logic [4:0]  w_back_idx;
    logic [4:0]  w_sel_idx;
    owner_t      w_sel_owner;
    logic [11:0] w_pix_rgb;
    logic [1:0]  w_hit;
    logic [1:0]  w_flash_on;

    assign w_hit = {bus.p2_hit, bus.p1_hit};

    // Simultaneous attacks cancel out and leave the current front player in place.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_front_p2 <= 1'b0;
        end else if (bus.p1_attack && !bus.p2_attack) begin
            r_front_p2 <= 1'b0;
        end else if (bus.p2_attack && !bus.p1_attack) begin
            r_front_p2 <= 1'b1;
        end
    end

    always_comb begin
        w_front_idx = r_front_p2 ? bus.p2_index : bus.p1_index;
        w_back_idx  = r_front_p2 ? bus.p1_index : bus.p2_index;
        w_sel_idx   = TRANSP;
        w_sel_owner = OWN_BG;
        if (w_front_idx != TRANSP) begin
            w_sel_idx   = w_front_idx;
            w_sel_owner = r_front_p2 ? OWN_P2 : OWN_P1;
        end else if (w_back_idx != TRANSP) begin
            w_sel_idx   = w_back_idx;
            w_sel_owner = r_front_p2 ? OWN_P1 : OWN_P2;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pal_index <= 5'd0;
            r_owner     <= OWN_BG;
            r_bg_rgb    <= 12'd0;
            r_s1_valid  <= 1'b0;
        end else begin
            r_s1_valid <= bus.pix_valid;
            if (bus.pix_valid) begin
                r_pal_index <= w_sel_idx;
                r_owner     <= w_sel_owner;
                r_bg_rgb    <= bus.bg_rgb;
            end
        end
    end

    assign bus.pal_index = r_pal_index;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_flash
            flash_state_t  r_state;
            flash_state_t  w_state_next;
            logic [FW-1:0] r_frame_cnt;
            logic [FW-1:0] w_frame_next;
            logic [PW-1:0] r_phase_cnt;
            logic [PW-1:0] w_phase_next;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    r_state     <= FL_IDLE;
                    r_frame_cnt <= '0;
                    r_phase_cnt <= '0;
                end else begin
                    r_state     <= w_state_next;
                    r_frame_cnt <= w_frame_next;
                    r_phase_cnt <= w_phase_next;
                end
            end

            // A hit always restarts the sequence, even on a frame boundary.
            always_comb begin
                w_state_next = r_state;
                w_frame_next = r_frame_cnt;
                w_phase_next = r_phase_cnt;
                if (w_hit[gi]) begin
                    w_state_next = FL_ON;
                    w_frame_next = '0;
                    w_phase_next = '0;
                end else if (bus.frame_start && r_state != FL_IDLE) begin
                    if (r_frame_cnt == FR_LAST) begin
                        w_frame_next = '0;
                        if (r_phase_cnt == PH_LAST) begin
                            w_state_next = FL_IDLE;
                            w_phase_next = '0;
                        end else begin
                            w_phase_next = r_phase_cnt + 1'b1;
                            w_state_next = (r_state == FL_ON) ? FL_OFF : FL_ON;
                        end
                    end else begin
                        w_frame_next = r_frame_cnt + 1'b1;
                    end
                end
            end

            assign w_flash_on[gi] = (r_state == FL_ON);
        end
    endgenerate

    always_comb begin
        w_pix_rgb = bus.pal_rgb;
        if (r_owner == OWN_BG) begin
            w_pix_rgb = r_bg_rgb;
        end else if ((r_owner == OWN_P1 && w_flash_on[0]) ||
                     (r_owner == OWN_P2 && w_flash_on[1])) begin
            w_pix_rgb = 12'hFFF;
        end
`ifdef RYU_P2_TINT_EN
        else if (r_owner == OWN_P2) begin
            w_pix_rgb = {bus.pal_rgb[3:0], bus.pal_rgb[7:4], bus.pal_rgb[11:8]};
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vga_rgb   <= 12'd0;
            r_vga_valid <= 1'b0;
        end else begin
            r_vga_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_vga_rgb <= w_pix_rgb;
            end
        end
    end

    assign bus.vga_rgb   = r_vga_rgb;
    assign bus.vga_valid = r_vga_valid;
endmodule

// File: tb/tb_ryu_pixel_sched.sv
// Directed bench for ryu_pixel_sched: a per-cycle behavioural model plus literal spot checks.
module tb_ryu_pixel_sched;
    localparam int NF = 4;
    localparam int NT = 6;
`ifdef RYU_P2_TINT_EN
    localparam logic [11:0] P2_IDX3 = 12'hCEE;
`else
    localparam logic [11:0] P2_IDX3 = 12'hEEC;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ryu_pixel_sched_if bus ();

    ryu_pixel_sched #(.FLASH_FRAMES(NF), .FLASH_TOGGLES(NT), .TRANSP_IDX(0)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] lut(input logic [4:0] i);
        case (i)
            5'd9:    return 12'hC10;
            5'd3:    return 12'hEEC;
            default: return {i[3:0], 3'b101, i[4], ~i[3:0]};
        endcase
    endfunction

    function automatic logic [11:0] swap_rb(input logic [11:0] c);
        return {c[3:0], c[7:4], c[11:8]};
    endfunction

    assign bus.pal_rgb = lut(bus.pal_index);

    // Behavioural model: flash expressed as frames elapsed since the last hit.
    bit          m_ready = 0;
    bit          m_front_p2;
    bit          m_act [2];
    int          m_frames [2];
    bit          m_s1_valid;
    int          m_owner;          // 0 = background, 1 = P1, 2 = P2
    logic [4:0]  m_pal;
    logic [11:0] m_bg;
    logic [11:0] m_vga;
    bit          m_vga_valid;

    function automatic bit flashing(input int p);
        return m_act[p] && ((m_frames[p] / NF) % 2 == 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 1; m_front_p2 = 0; m_s1_valid = 0; m_owner = 0;
            m_pal = 5'd0; m_bg = 12'd0; m_vga = 12'd0; m_vga_valid = 0;
            for (int p = 0; p < 2; p++) begin m_act[p] = 0; m_frames[p] = 0; end
        end else begin
            bit  hit [2];
            int  fi, bi;
            if (m_s1_valid) begin
                if (m_owner == 0)                  m_vga = m_bg;
                else if (flashing(m_owner - 1))    m_vga = 12'hFFF;
`ifdef RYU_P2_TINT_EN
                else if (m_owner == 2)             m_vga = swap_rb(lut(m_pal));
`endif
                else                               m_vga = lut(m_pal);
            end
            m_vga_valid = m_s1_valid;
            m_s1_valid  = bus.pix_valid;
            if (bus.pix_valid) begin
                fi = m_front_p2 ? 2 : 1;
                bi = m_front_p2 ? 1 : 2;
                m_bg = bus.bg_rgb;
                if ((fi == 1 ? bus.p1_index : bus.p2_index) != 5'd0) begin
                    m_owner = fi; m_pal = (fi == 1) ? bus.p1_index : bus.p2_index;
                end else if ((bi == 1 ? bus.p1_index : bus.p2_index) != 5'd0) begin
                    m_owner = bi; m_pal = (bi == 1) ? bus.p1_index : bus.p2_index;
                end else begin
                    m_owner = 0; m_pal = 5'd0;
                end
            end
            if (bus.p1_attack != bus.p2_attack) m_front_p2 = bus.p2_attack;
            hit[0] = bus.p1_hit;
            hit[1] = bus.p2_hit;
            for (int p = 0; p < 2; p++) begin
                if (hit[p]) begin
                    m_act[p] = 1; m_frames[p] = 0;
                end else if (bus.frame_start && m_act[p]) begin
                    m_frames[p]++;
                    if (m_frames[p] == NF * NT) m_act[p] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            total += 3;
            if (bus.pal_index !== m_pal) begin
                bad++;
                $display("FAIL model_pal_index t=%0t got %0d want %0d", $time, bus.pal_index, m_pal);
            end
            if (bus.vga_valid !== m_vga_valid) begin
                bad++;
                $display("FAIL model_vga_valid t=%0t got %0b want %0b", $time, bus.vga_valid, m_vga_valid);
            end
            if (bus.vga_rgb !== m_vga) begin
                bad++;
                $display("FAIL model_vga_rgb t=%0t got %h want %h", $time, bus.vga_rgb, m_vga);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic frame_pulse(input int gap);
        repeat (gap) cyc();
        bus.frame_start = 1'b1;
        cyc();
        bus.frame_start = 1'b0;
    endtask

    initial begin
        bus.frame_start = 0; bus.pix_valid = 0; bus.p1_index = 0; bus.p2_index = 0;
        bus.p1_attack = 0; bus.p2_attack = 0; bus.p1_hit = 0; bus.p2_hit = 0;
        bus.bg_rgb = 12'h000;
        repeat (3) cyc();
        check("rst_pal_index", 12'(bus.pal_index), 12'h000);
        check("rst_vga_rgb", bus.vga_rgb, 12'h000);
        check("rst_vga_valid", 12'(bus.vga_valid), 12'h000);
        rst = 0;

        // front P1 wins over P2, then transparent P1 lets P2 through
        bus.p1_index = 9; bus.p2_index = 3; bus.bg_rgb = 12'h123; bus.pix_valid = 1;
        cyc(); check("prio_pal_index", 12'(bus.pal_index), 12'h009);
        bus.p1_index = 0;
        cyc(); check("prio_vga_rgb", bus.vga_rgb, 12'hC10);
        check("prio_vga_valid", 12'(bus.vga_valid), 12'h001);
        bus.pix_valid = 0;
        cyc(); check("transp_vga_rgb", bus.vga_rgb, P2_IDX3);
        cyc(); check("idle_vga_valid", 12'(bus.vga_valid), 12'h000);
        check("idle_vga_hold", bus.vga_rgb, P2_IDX3);

        // background only
        bus.p1_index = 0; bus.p2_index = 0; bus.bg_rgb = 12'h348; bus.pix_valid = 1;
        cyc(); check("bg_pal_index", 12'(bus.pal_index), 12'h000);
        bus.pix_valid = 0;
        cyc(); check("bg_vga_rgb", bus.vga_rgb, 12'h348);

        // attack priority
        bus.p2_attack = 1; cyc(); bus.p2_attack = 0;
        bus.p1_index = 9; bus.p2_index = 3; bus.pix_valid = 1;
        cyc(); bus.pix_valid = 0;
        cyc(); check("atk_p2_front", bus.vga_rgb, P2_IDX3);
        bus.p1_attack = 1; bus.p2_attack = 1; cyc(); bus.p1_attack = 0; bus.p2_attack = 0;
        bus.pix_valid = 1; cyc(); bus.pix_valid = 0;
        cyc(); check("atk_both_keep", bus.vga_rgb, P2_IDX3);
        bus.p1_attack = 1; cyc(); bus.p1_attack = 0;
        bus.pix_valid = 1; cyc(); bus.pix_valid = 0;
        cyc(); check("atk_p1_front", bus.vga_rgb, 12'hC10);

        // P1 flash over a full sequence
        bus.pix_valid = 1; bus.p1_index = 9; bus.p2_index = 3;
        bus.p1_hit = 1; cyc(); bus.p1_hit = 0;
        for (int k = 0; k <= NF * NT; k++) begin
            repeat (3) cyc();
            check($sformatf("flash_frame%0d", k), bus.vga_rgb,
                  (k < NF * NT && ((k / NF) % 2 == 0)) ? 12'hFFF : 12'hC10);
            bus.frame_start = 1; cyc(); bus.frame_start = 0;
        end

        // re-hit coinciding with a frame_start at frame 10 restarts the ON phase
        bus.p1_hit = 1; cyc(); bus.p1_hit = 0;
        for (int k = 0; k < 10; k++) frame_pulse(2);
        bus.p1_hit = 1; bus.frame_start = 1; cyc(); bus.p1_hit = 0; bus.frame_start = 0;
        for (int k = 0; k < 3; k++) frame_pulse(2);
        repeat (3) cyc(); check("rehit_on", bus.vga_rgb, 12'hFFF);
        frame_pulse(0);
        repeat (3) cyc(); check("rehit_off", bus.vga_rgb, 12'hC10);

        // P2 flash, then reset mid-stream
        bus.p2_attack = 1; cyc(); bus.p2_attack = 0;
        bus.p1_index = 0; bus.p2_index = 3;
        bus.p2_hit = 1; cyc(); bus.p2_hit = 0;
        repeat (3) cyc(); check("p2_flash_on", bus.vga_rgb, 12'hFFF);
        check("p2_flash_valid", 12'(bus.vga_valid), 12'h001);
        rst = 1; cyc();
        check("rst_mid_vga_rgb", bus.vga_rgb, 12'h000);
        check("rst_mid_vga_valid", 12'(bus.vga_valid), 12'h000);
        rst = 0; cyc();
        check("rst_flush_valid", 12'(bus.vga_valid), 12'h000);
        cyc(); check("rst_flash_cancel", bus.vga_rgb, P2_IDX3);
        bus.p1_index = 9;
        cyc(); cyc(); check("rst_front_p1", bus.vga_rgb, 12'hC10);

        bus.pix_valid = 0;
        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ryu_pixel_sched.md
Name: ryu_pixel_sched

Overview:
- Per-pixel scheduler that shares the single 32-entry fighter palette LUT between the two player sprite pipelines (P1, P2) and the background.
- Each pixel cycle it decides front/back priority and transparency, and drives the palette index.
- It then composites the palette colour with the background and applies hit-flash and optional P2 tint.
- Sits between the sprite ROM address/index logic and the VGA colour output.

Parameters:
- FLASH_FRAMES, 4: frames per flash phase (on or off).
- FLASH_TOGGLES, 6: number of phases per hit (even; ends in off).
- TRANSP_IDX, 0: palette index treated as transparent.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vsync
- pix_valid  in  1  pixel slot valid this cycle
- p1_index  in  5  P1 sprite palette index (TRANSP_IDX = no pixel)
- p2_index  in  5  P2 sprite palette index
- p1_attack  in  1  pulse: P1 started attack (raises P1 priority)
- p2_attack  in  1  pulse: P2 started attack
- p1_hit  in  1  pulse: P1 took damage (start P1 flash)
- p2_hit  in  1  pulse: P2 took damage
- bg_rgb  in  12  background colour {r,g,b}
- pal_index  out  5  index to palette LUT (registered)
- pal_rgb  in  12  palette LUT colour for pal_index (combinational return)
- vga_rgb  out  12  composited colour {r,g,b}
- vga_valid  out  1  vga_rgb valid

Behaviour:
- Reset values: pal_index=0, vga_rgb=0, vga_valid=0. front=P1. Both flash FSMs IDLE, counters 0. Pipeline valid bits 0.
- Priority register front:
  - p1_attack only -> front=P1; p2_attack only -> front=P2.
  - Both in the same cycle -> unchanged.
  - Updates take effect for the pixel presented the following cycle.
- Stage 1 (cycle N, pix_valid=1):
  - Choose the front player's index if it is not TRANSP_IDX; else the back player's index if not TRANSP_IDX; else none.
  - Register pal_index = chosen index (TRANSP_IDX if none), plus sel_owner (P1/P2/BG), bg_rgb and s1_valid.
  - pix_valid=0 -> s1_valid=0; pal_index holds.
- Stage 2 (cycle N+1):
  - owner BG -> bg_rgb.
  - Owner in flash ON phase -> 12'hFFF.
  - Otherwise pal_rgb (with tint, see Optional Feature).
  - Register into vga_rgb; vga_valid = s1_valid. Latency exactly 2 cycles, fully pipelined, one pixel per cycle.
- vga_rgb holds its last value when vga_valid=0.
- Flash FSM, one per player:
  - States: IDLE, ON, OFF. Counters: frame_cnt (counts to FLASH_FRAMES-1) and phase_cnt (counts to FLASH_TOGGLES-1).
  - hit pulse in any state -> ON, frame_cnt=0, phase_cnt=0 (restart).
  - Each frame_start: if frame_cnt==FLASH_FRAMES-1 then frame_cnt=0, toggle ON/OFF, phase_cnt++; else frame_cnt++.
  - When phase_cnt would reach FLASH_TOGGLES -> IDLE.
  - hit and frame_start in the same cycle -> hit wins (restart).
  - State changes apply to stage 2 from the next cycle; no mid-pixel glitch.
- Reset mid-operation: the pipeline flushes (no vga_valid for 2 cycles after release), flashes cancel, front=P1.

Optional Feature:
- Macro: RYU_P2_TINT_EN.
- Defined: when the owner is P2 and not flashing, stage 2 outputs {pal_rgb[3:0], pal_rgb[7:4], pal_rgb[11:8]}, i.e. red/blue swapped, for mirror-match colouring. P1 and BG are unaffected.
- Undefined: P2 uses pal_rgb unmodified; no extra logic.

Test Plan:
- Priority/transparency: front=P1, p1_index=9, p2_index=3, LUT model (9->12'hC10, 3->12'hEEC).
  - pal_index=9 at N+1; vga_rgb=12'hC10, vga_valid=1 at N+2.
  - Then p1_index=0 -> vga_rgb=12'hEEC.
- Background: p1_index=p2_index=0, bg_rgb=12'h348 -> vga_rgb=12'h348 two cycles later; pal_index=0.
- Attack priority: p2_attack pulse, then p1_index=9, p2_index=3 -> vga_rgb=12'hEEC.
  - Both attacks in the same cycle -> front stays P2.
- Flash: p1_hit, then 24 frame_start pulses, P1 pixel idx 9.
  - Frames 0-3 output 12'hFFF, frames 4-7 12'hC10, alternating.
  - After the 24th pulse, FSM IDLE and output 12'hC10.
  - A re-hit at frame 10 restarts the ON phase.
- Reset mid-stream: assert Reset with vga_valid=1 -> next cycle vga_rgb=0, vga_valid=0, flash cancelled, front=P1.
- RYU_P2_TINT_EN defined: P2-owned idx 3 (12'hEEC) -> vga_rgb=12'hCEE; undefined -> 12'hEEC.
